// File: rtl/maxpool_multi_window.sv
// Channel-sequential K x K max-pool engine with stride and symmetric padding.
// One pooled element per cycle. The input is captured on start and results land in a registered tensor.
module maxpool_multi_window #(
   parameter int DATA_WIDTH = 16,
   parameter int D          = 2,
   parameter int H          = 13,
   parameter int W          = 13,
   parameter int K          = 5,
   parameter int S          = 1,
   parameter int PAD        = 2
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [0:H*W*D*DATA_WIDTH-1]            mpInput,
   output logic                                   busy,
   output logic                                   done,
   output logic [0:((H+2*PAD-K)/S+1)*((W+2*PAD-K)/S+1)*D*DATA_WIDTH-1] mpOutput
);

   localparam int OH       = (H + 2*PAD - K) / S + 1;
   localparam int OW       = (W + 2*PAD - K) / S + 1;
   localparam int IN_BITS  = H * W * D * DATA_WIDTH;
   localparam int OUT_BITS = OH * OW * D * DATA_WIDTH;
   localparam int IN_AW    = $clog2(IN_BITS);
   localparam int OUT_AW   = $clog2(OUT_BITS);
   localparam int CW       = (D  > 1) ? $clog2(D)  : 1;
   localparam int RW       = (OH > 1) ? $clog2(OH) : 1;
   localparam int QW       = (OW > 1) ? $clog2(OW) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                       state;
   state_t                       state_next;
   logic [0:IN_BITS-1]           in_buf;
   logic [0:OUT_BITS-1]          out_buf;
   logic [CW-1:0]                c_cnt;
   logic [RW-1:0]                r_cnt;
   logic [QW-1:0]                q_cnt;
   logic                         q_wrap;
   logic                         r_wrap;
   logic                         last;
   logic signed [DATA_WIDTH-1:0] win_max;
   logic signed [DATA_WIDTH-1:0] elem;
   logic signed [31:0]           win_row;
   logic signed [31:0]           win_col;
   logic [OUT_AW-1:0]            wr_base;

   assign q_wrap   = (q_cnt == QW'(OW - 1));
   assign r_wrap   = (r_cnt == RW'(OH - 1));
   assign last     = q_wrap && r_wrap && (c_cnt == CW'(D - 1));
   assign wr_base  = OUT_AW'(((int'(c_cnt) * OH + int'(r_cnt)) * OW + int'(q_cnt)) * DATA_WIDTH);
   assign mpOutput = out_buf;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Padded cells never beat the most-negative seed, so skipping them is
   // equivalent to comparing against -2^(DATA_WIDTH-1).
   always_comb begin
      win_max = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      elem    = '0;
      win_row = '0;
      win_col = '0;
      for (int unsigned i = 0; i < K; i++) begin
         for (int unsigned j = 0; j < K; j++) begin
            win_row = int'(r_cnt) * S - PAD + int'(i);
            win_col = int'(q_cnt) * S - PAD + int'(j);
            if (win_row >= 0 && win_row < H && win_col >= 0 && win_col < W) begin
               elem = in_buf[IN_AW'(((int'(c_cnt) * H + win_row) * W + win_col) * DATA_WIDTH) +: DATA_WIDTH];
               if (elem > win_max) win_max = elem;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_buf  <= '0;
         out_buf <= '0;
         c_cnt   <= '0;
         r_cnt   <= '0;
         q_cnt   <= '0;
      end else if (state == IDLE && start) begin
         in_buf <= mpInput;
         c_cnt  <= '0;
         r_cnt  <= '0;
         q_cnt  <= '0;
      end else if (state == RUN) begin
         out_buf[wr_base +: DATA_WIDTH] <= win_max;
         if (q_wrap) begin
            q_cnt <= '0;
            if (r_wrap) begin
               r_cnt <= '0;
               c_cnt <= last ? '0 : c_cnt + 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            q_cnt <= q_cnt + 1'b1;
         end
      end
   end

endmodule
